// File: rtl/icache_dm_pkg.sv
// Shared definitions for the direct-mapped instruction cache.
//   - bus word/address widths and their types
//   - controller state encoding (exported on the debug port)
//   - is_cacheable(): window test used by the request lookup
package icache_dm_pkg;

    localparam int unsigned P_WADDR = 32;
    localparam int unsigned P_WDATA = 32;

    typedef logic [P_WADDR-1:0] addr_t;
    typedef logic [P_WDATA-1:0] data_t;

    typedef enum logic [2:0] {
        S_RUN         = 3'd0,
        S_REFILL_REQ  = 3'd1,
        S_REFILL_DATA = 3'd2,
        S_UNC_REQ     = 3'd3,
        S_UNC_DATA    = 3'd4,
        S_WR          = 3'd5
    } state_e;

    // Window bounds are inclusive on both ends.
    function automatic logic is_cacheable(input addr_t a, input addr_t lo, input addr_t hi);
        return (a >= lo) && (a <= hi);
    endfunction

endpackage

// File: rtl/BusItf.sv
// Single-word request/response bus used on both sides of the cache.
//   valid/wr/addr/dataM2S : master -> slave request, held until ready=1
//   ready                 : slave accepts the request in this cycle
//   dataS2M               : read data, valid only in the cycle after ready,
//                           zero in every other cycle
interface BusItf;
    logic        valid;
    logic        ready;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] dataM2S;
    logic [31:0] dataS2M;

    modport Master (output valid, output wr, output addr, output dataM2S,
                    input  ready, input  dataS2M);
    modport Slave  (input  valid, input  wr, input  addr, input  dataM2S,
                    output ready, output dataS2M);
endinterface

// File: rtl/icache_dm_bram.sv
// Single-port data array with a registered read port (1-cycle latency).
//   clk   : clock
//   en    : access enable
//   we    : write when en=1, otherwise read
//   addr  : word address
//   wdata : write data
//   rdata : read data, valid the cycle after a read access
module icache_dm_bram #(
    parameter int unsigned P_DEPTH = 64,
    parameter int unsigned P_WIDTH = 32,
    parameter int unsigned P_AW    = 6
) (
    input  logic               clk,
    input  logic               en,
    input  logic               we,
    input  logic [P_AW-1:0]    addr,
    input  logic [P_WIDTH-1:0] wdata,
    output logic [P_WIDTH-1:0] rdata
);

    // No reset on the array or the read register so it maps onto block RAM;
    // the cache gates rdata with its own registered "read happened" flag.
    logic [P_WIDTH-1:0] mem [P_DEPTH];
    logic [P_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata_q <= mem[addr];
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped instruction cache between the CPU fetch port and the bus.
//   clk, rst  : clock, asynchronous active-low reset
//   flush     : one-cycle pulse, invalidates every line
//   bCpuIf    : CPU-side slave port
//   bBusIf    : system-bus master port
//   hitCnt    : cacheable read hits since reset (wraps)
//   missCnt   : refills started since reset (wraps)
//   dbg_state : current controller state
// Handshake on both ports: the master holds valid/addr/wr/dataM2S until the
// cycle ready=1; read data appears on dataS2M in the following cycle and
// dataS2M is zero otherwise.
module icache_dm
    import icache_dm_pkg::*;
#(
    parameter int unsigned P_LINES    = 16,
    parameter int unsigned P_WORDS    = 4,
    parameter logic [31:0] P_CACHE_LO = 32'h0000_0000,
    parameter logic [31:0] P_CACHE_HI = 32'h0000_FFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    BusItf.Slave        bCpuIf,
    BusItf.Master       bBusIf,
    output logic [31:0] hitCnt,
    output logic [31:0] missCnt,
    output state_e      dbg_state
);

    localparam int unsigned WW = $clog2(P_WORDS);
    localparam int unsigned IW = $clog2(P_LINES);
    localparam int unsigned TW = P_WADDR - 2 - WW - IW;
    localparam int unsigned AW = IW + WW;

    state_e            state_q, state_d;
    logic [WW-1:0]     word_q, word_d;
    logic [P_LINES-1:0] valid_q, valid_d;
    logic [TW-1:0]     tag_q [P_LINES];
    logic [TW-1:0]     tag_d [P_LINES];
    logic [31:0]       hit_cnt_q, hit_cnt_d;
    logic [31:0]       miss_cnt_q, miss_cnt_d;
    logic              flush_pend_q, flush_pend_d;
    logic              rd_hit_q, rd_hit_d;
    logic              retry_q, retry_d;

    logic [WW-1:0]     req_word;
    logic [IW-1:0]     req_index;
    logic [TW-1:0]     req_tag;
    logic              cacheable, tag_hit;

    logic              cpu_ready, bus_valid, bus_wr;
    addr_t             bus_addr;
    data_t             bus_wdata;
    logic              ram_en, ram_we;
    logic [AW-1:0]     ram_addr;
    data_t             ram_wdata, ram_rdata;

    assign req_word  = bCpuIf.addr[2 +: WW];
    assign req_index = bCpuIf.addr[2 + WW +: IW];
    assign req_tag   = bCpuIf.addr[P_WADDR-1 -: TW];
    assign cacheable = is_cacheable(bCpuIf.addr, P_CACHE_LO, P_CACHE_HI);
    assign tag_hit   = valid_q[req_index] && (tag_q[req_index] == req_tag);

    always_comb begin
        state_d      = state_q;
        word_d       = word_q;
        valid_d      = valid_q;
        tag_d        = tag_q;
        hit_cnt_d    = hit_cnt_q;
        miss_cnt_d   = miss_cnt_q;
        flush_pend_d = flush_pend_q;
        rd_hit_d     = 1'b0;
        retry_d      = 1'b0;
        cpu_ready    = 1'b0;
        bus_valid    = 1'b0;
        bus_wr       = 1'b0;
        bus_addr     = '0;
        bus_wdata    = '0;
        ram_en       = 1'b0;
        ram_we       = 1'b0;
        ram_addr     = {req_index, req_word};
        ram_wdata    = bCpuIf.dataM2S;

        unique case (state_q)
            S_RUN: begin
                if (bCpuIf.valid) begin
                    if (bCpuIf.wr) begin
                        state_d = S_WR;
                    end else if (!cacheable) begin
                        state_d = S_UNC_REQ;
                    end else if (tag_hit) begin
                        cpu_ready = 1'b1;
                        ram_en    = 1'b1;
                        rd_hit_d  = 1'b1;
                        // The re-lookup that ends a refill was already
                        // counted as a miss; count each request only once.
                        if (!retry_q) begin
                            hit_cnt_d = hit_cnt_q + 32'd1;
                        end
                    end else begin
                        miss_cnt_d = miss_cnt_q + 32'd1;
                        word_d     = '0;
                        state_d    = S_REFILL_REQ;
                    end
                end
            end
            S_REFILL_REQ: begin
                bus_valid = 1'b1;
                bus_addr  = {req_tag, req_index, word_q, 2'b00};
                if (bBusIf.ready) begin
                    state_d = S_REFILL_DATA;
                end
            end
            S_REFILL_DATA: begin
                ram_en    = 1'b1;
                ram_we    = 1'b1;
                ram_addr  = {req_index, word_q};
                ram_wdata = bBusIf.dataS2M;
                if (word_q == WW'(P_WORDS - 1)) begin
                    tag_d[req_index]   = req_tag;
                    valid_d[req_index] = 1'b1;
                    retry_d            = 1'b1;
                    state_d            = S_RUN;
                end else begin
                    word_d  = word_q + WW'(1);
                    state_d = S_REFILL_REQ;
                end
            end
            S_UNC_REQ: begin
                bus_valid = 1'b1;
                bus_addr  = bCpuIf.addr;
                cpu_ready = bBusIf.ready;
                if (bBusIf.ready) begin
                    state_d = S_UNC_DATA;
                end
            end
            S_UNC_DATA: begin
                state_d = S_RUN;
            end
            S_WR: begin
                bus_valid = 1'b1;
                bus_wr    = 1'b1;
                bus_addr  = bCpuIf.addr;
                bus_wdata = bCpuIf.dataM2S;
                cpu_ready = bBusIf.ready;
                if (bBusIf.ready) begin
                    // Write-through: update a resident copy, never allocate.
                    if (cacheable && tag_hit) begin
                        ram_en = 1'b1;
                        ram_we = 1'b1;
                    end
                    state_d = S_RUN;
                end
            end
            default: begin
                state_d = S_RUN;
            end
        endcase

        // Flush wins over a line being validated on the same edge, so a
        // flush that arrives during a refill forces the request to re-miss.
        if (state_q == S_RUN) begin
            if (flush) begin
                valid_d = '0;
            end
            flush_pend_d = 1'b0;
        end else if (state_d == S_RUN) begin
            if (flush_pend_q || flush) begin
                valid_d = '0;
            end
            flush_pend_d = 1'b0;
        end else if (flush) begin
            flush_pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_RUN;
            word_q       <= '0;
            valid_q      <= '0;
            for (int i = 0; i < P_LINES; i++) begin
                tag_q[i] <= '0;
            end
            hit_cnt_q    <= '0;
            miss_cnt_q   <= '0;
            flush_pend_q <= 1'b0;
            rd_hit_q     <= 1'b0;
            retry_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            word_q       <= word_d;
            valid_q      <= valid_d;
            tag_q        <= tag_d;
            hit_cnt_q    <= hit_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
            flush_pend_q <= flush_pend_d;
            rd_hit_q     <= rd_hit_d;
            retry_q      <= retry_d;
        end
    end

    icache_dm_bram #(
        .P_DEPTH (P_LINES * P_WORDS),
        .P_WIDTH (P_WDATA),
        .P_AW    (AW)
    ) u_data (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    assign bCpuIf.ready   = cpu_ready;
    assign bCpuIf.dataS2M = (state_q == S_UNC_DATA) ? bBusIf.dataS2M :
                            (rd_hit_q ? ram_rdata : '0);
    assign bBusIf.valid   = bus_valid;
    assign bBusIf.wr      = bus_wr;
    assign bBusIf.addr    = bus_addr;
    assign bBusIf.dataM2S = bus_wdata;
    assign hitCnt         = hit_cnt_q;
    assign missCnt        = miss_cnt_q;
    assign dbg_state      = state_q;

endmodule

// File: doc/icache_dm.md
Name: icache_dm

Overview:
- Direct-mapped, parametrised instruction cache between the CPU fetch port and the system bus.
- Cacheable fetches hit in local BRAM; misses refill a whole line from the bus with single-word transactions.
- Accesses outside the cacheable window pass through uncached.
- CPU writes are write-through, no-allocate. Software-visible flush and hit/miss counters added.

Parameters:
- P_LINES, 16, number of cache lines (power of 2, >=2)
- P_WORDS, 4, 32-bit words per line (power of 2, >=2)
- P_CACHE_LO, 32'h0000_0000, first cacheable byte address (line aligned)
- P_CACHE_HI, 32'h0000_FFFF, last cacheable byte address inclusive

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- flush  in  1  one-cycle pulse; invalidate all lines
- bCpuIf  BusItf.Slave  -  CPU side: valid, ready, wr, addr[32], dataM2S[32], dataS2M[32]
- bBusIf  BusItf.Master  -  bus side: same signal set
- hitCnt  out  32  cacheable read hits since reset, wraps
- missCnt  out  32  cacheable read misses (refills started) since reset, wraps

Behaviour:
- Reset: all valid bits 0; state S_RUN; bBusIf.valid=0; bCpuIf.ready=0; bCpuIf.dataS2M=0; counters 0; pending flush 0. Reset mid-refill abandons the refill; the line stays invalid.
- Address split: [1:0] ignored; word = [2 +: log2 P_WORDS]; index = next log2 P_LINES bits; tag = remaining upper bits.
- Cacheable = P_CACHE_LO <= addr <= P_CACHE_HI. Tags and valid bits are held in flops, so lookup is combinational in the request cycle.
- Bus protocol, both sides:
  - Master holds valid/addr/wr/dataM2S until the cycle ready=1.
  - Read data is on dataS2M the cycle after ready.
  - dataS2M is 0 in all other cycles.
- States: S_RUN, S_REFILL_REQ, S_REFILL_DATA, S_UNC_REQ, S_UNC_DATA, S_WR.
- S_RUN, read, cacheable hit:
  - ready=1 in the same cycle; BRAM read enabled; hitCnt++.
  - Data on bCpuIf.dataS2M next cycle.
  - Back-to-back hits sustain 1 word/cycle.
- S_RUN, read, cacheable miss:
  - ready=0; missCnt++; word counter=0.
  - Go to S_REFILL_REQ.
- S_REFILL_REQ:
  - bBusIf.valid=1, wr=0, addr={tag,index,counter,2'b00}.
  - On bus ready, go to S_REFILL_DATA.
- S_REFILL_DATA:
  - Write bus dataS2M into BRAM at {index,counter}.
  - If counter == P_WORDS-1: write tag, set valid, go to S_RUN. The pending CPU request then re-looks-up and hits.
  - Otherwise: counter++ and return to S_REFILL_REQ.
  - Miss-to-ready latency = 2*P_WORDS + 1 cycles with a zero-wait bus.
- S_RUN, read, uncacheable:
  - Go to S_UNC_REQ: forward the request; bCpuIf.ready mirrors bBusIf.ready.
  - Go to S_UNC_DATA: pass bus dataS2M to the CPU for one cycle, then S_RUN.
  - Counters are unchanged.
- S_RUN, write (any address):
  - Go to S_WR: forward to the bus; bCpuIf.ready mirrors bBusIf.ready.
  - In the ready cycle, if cacheable and tag hit, write dataM2S into BRAM (write-through).
  - No allocate on write miss. Return to S_RUN.
- Flush:
  - In S_RUN: all valid bits clear at the next edge. A hit lookup in that same cycle still completes.
  - In any other state: latch pending flush and apply it on return to S_RUN. A just-refilled line is invalidated, so the CPU request re-misses.
  - flush during reset is ignored.
- CPU valid dropped while the block is busy is a protocol violation; behaviour undefined.
- Counter wrap: 32'hFFFF_FFFF + 1 gives 0.

Decomposition:
- New package ICachePkg, importing BusPkg for type_Addr/type_Data:
  - localparams for index/word/tag widths derived from the parameters.
  - type_State enum.
  - Functions getIndex/getWord/getTag.
- Data array: one Bram sub-module instance, depth P_LINES*P_WORDS, width P_WDATA, single port, 1-cycle read.
- Tag/valid array: in-module flops.

Test Plan:
- Cold read at 0x0000_0040, zero-wait bus returns 0x11,0x22,0x33,0x44 for words 0x40..0x4C -> 4 bus reads at 0x40,0x44,0x48,0x4C; CPU ready 9 cycles after valid; dataS2M=0x11; missCnt=1.
- Then consecutive reads 0x44,0x48,0x4C -> ready same cycle each; data 0x22,0x33,0x44 on successive cycles; hitCnt=3; no bus valid.
- Read 0x0000_0440 (same index, different tag, 16x4 config) -> refill evicts the line; a later read of 0x40 misses again; missCnt=3.
- Write 0xDEAD_BEEF to cached 0x48 -> one bus write; subsequent read of 0x48 hits and returns 0xDEAD_BEEF.
- Read uncached 0x1000_0000 with bus ready delayed 3 cycles -> CPU ready coincides with bus ready; data next cycle; counters unchanged.
- Flush pulse mid-refill, then assert rst during a second refill -> line refetched after the first; after reset all reads miss and counters read 0.
